// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, owner codes,
// default line size and a small owner-to-grant helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BURST = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int LINE_WORDS_DEF = 8;

  // One-hot grant vector for an owner code: bit0 = I, bit1 = D.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return (owner == OWN_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the I and D requesters.
// Default: fixed priority, D over I.
// With MEM_ARB_RR_EN defined: on a tie the requester not served last wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_owner,
  output logic any_req,
  output logic pick
);

  // Pick the winning owner among the active requests.
  always_comb begin
    any_req = i_req | d_req;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      pick = ~last_owner;
    end else begin
      pick = d_req ? OWN_D : OWN_I;
    end
`else
    pick = d_req ? OWN_D : OWN_I;
`endif
  end

`ifndef MEM_ARB_RR_EN
  // History has no influence on a fixed-priority pick.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between the I-cache refill path and the D-cache
// refill/writeback path. Moves one LINE_WORDS-beat burst at a time.
// Optional round-robin arbitration: define MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_wnext,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ack,
  output logic [1:0]        gnt
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_t          state_reg, state_next;
  logic                owner_reg, owner_next;
  logic                we_reg, we_next;
  logic [BASE_W-1:0]   base_reg, base_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic [31:0]         i_rdata_reg, d_rdata_reg;
  logic                i_rvalid_reg, d_rvalid_reg;
  logic                last_owner;
  logic                any_req;
  logic                pick;
  logic                in_burst;
  logic                beat_ack;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .any_req    (any_req),
    .pick       (pick)
  );

`ifdef MEM_ARB_RR_EN
  logic last_owner_reg;
  // Remember the most recent grant so that ties alternate; starts at D so I wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_reg <= OWN_D;
    end else if (state_reg == ARB_IDLE && any_req) begin
      last_owner_reg <= pick;
    end
  end
  assign last_owner = last_owner_reg;
`else
  assign last_owner = OWN_D;
`endif

  // Offset bits inside a line are implied by the beat counter.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  assign in_burst = (state_reg == ARB_BURST);
  assign beat_ack = in_burst && mem_ack;

  // FSM and burst-context registers; a reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
      owner_reg <= OWN_I;
      we_reg    <= 1'b0;
      base_reg  <= '0;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      base_reg  <= base_next;
      beat_reg  <= beat_next;
    end
  end

  // Next-state logic: latch the request in IDLE, count acked beats in BURST, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    we_next    = we_reg;
    base_next  = base_reg;
    beat_next  = beat_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          owner_next = pick;
          we_next    = (pick == OWN_D) && d_we;
          base_next  = (pick == OWN_D) ? d_addr[ADDR_W-1:OFF_W] : i_addr[ADDR_W-1:OFF_W];
          beat_next  = '0;
          state_next = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (mem_ack) begin
          if (beat_reg == LAST_BEAT) begin
            state_next = ARB_DONE;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Read data returns to the owner one cycle after the memory acknowledges the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
    end else begin
      i_rvalid_reg <= beat_ack && !we_reg && (owner_reg == OWN_I);
      d_rvalid_reg <= beat_ack && !we_reg && (owner_reg == OWN_D);
      if (beat_ack && !we_reg) begin
        if (owner_reg == OWN_I) begin
          i_rdata_reg <= mem_dout;
        end else begin
          d_rdata_reg <= mem_dout;
        end
      end
    end
  end

  assign mem_en   = in_burst;
  assign mem_we   = in_burst && we_reg;
  assign mem_addr = in_burst ? {base_reg, beat_reg, 2'b00} : '0;
  assign mem_din  = (in_burst && we_reg) ? d_wdata : '0;
  assign d_wnext  = beat_ack && we_reg;

  assign i_rdata  = i_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign i_rvalid = i_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign i_done   = (state_reg == ARB_DONE) && (owner_reg == OWN_I);
  assign d_done   = (state_reg == ARB_DONE) && (owner_reg == OWN_D);
  assign gnt      = (state_reg == ARB_IDLE) ? 2'b00 : owner_onehot(owner_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single bursts, hand-written
// corner sequences (tie, continuous requests, address change, reset mid-burst)
// and randomized bursts checked against a burst-level reference model.
module tb_mem_arbiter;

  localparam int L = 8;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
  logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done;
  logic        mem_en, mem_we, mem_ack;
  logic [1:0]  gnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:2047];
  logic [31:0] wwords [0:15];
  int          wait_cfg = 0;
  int          wcnt = 0;
  int          widx = 0;
  logic        last_served = OWN_D;

  mem_arbiter #(.LINE_WORDS(L), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  // Memory responder: acknowledges after wait_cfg wait cycles per beat.
  assign mem_ack  = mem_en && (wcnt >= wait_cfg);
  assign mem_dout = mem[mem_addr[12:2]];
  always @(posedge clk) begin
    if (!mem_en || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Arbitration rule: single requester wins; ties go to D, or alternate under round-robin.
  function automatic logic model_pick(input logic ir, input logic dr);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return ~last_served;
`else
      return OWN_D;
`endif
    end
    return dr ? OWN_D : OWN_I;
  endfunction

  // Runs one burst from the current request state and checks it beat by beat.
  task automatic run_burst(input logic exp_own, input logic [31:0] exp_base, input logic exp_we,
                           input int waitc, input int chg_beat, input int rst_beat, input bit keep);
    int idle, acks, cyc;
    bit ack_prev, done_seen, advance;
    logic [31:0] rd_prev, ea;
    logic exp_done;
    wait_cfg = waitc;
    widx = 0;
    d_wdata = wwords[0];
    idle = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
      idle++;
    end
    chk("gnt", {30'd0, gnt}, {30'd0, exp_own, ~exp_own});
    if (gnt == 2'b00) return;
    chk("idle_gap", 32'(idle), 32'd1);
    last_served = exp_own;
    $display("burst owner=%s base=%h we=%0d wait=%0d", exp_own ? "D" : "I", exp_base, exp_we, waitc);
    acks = 0; ack_prev = 0; done_seen = 0; rd_prev = '0;
    for (cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      advance = 0;
      if (rst_beat >= 0 && acks == rst_beat) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_served = OWN_D;
        repeat (3) @(negedge clk);
        chk("post_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
        return;
      end
      if (exp_own == OWN_I) begin
        chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, ack_prev && !exp_we});
        if (ack_prev && !exp_we) chk("i_rdata", i_rdata, rd_prev);
      end else begin
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, ack_prev && !exp_we});
        if (ack_prev && !exp_we) chk("d_rdata", d_rdata, rd_prev);
      end
      exp_done = (acks == L);
      chk("done", {31'd0, (exp_own == OWN_D) ? d_done : i_done}, {31'd0, exp_done});
      ack_prev = 0;
      if (acks == L) begin
        chk("mem_en_after_last", {31'd0, mem_en}, 32'd0);
        done_seen = 1;
      end else if (mem_ack) begin
        ea = exp_base + 32'(4 * acks);
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("d_wnext", {31'd0, d_wnext}, {31'd0, exp_we});
        if (exp_we) begin
          chk("mem_din", mem_din, wwords[acks]);
          mem[ea[12:2]] = wwords[acks];
          advance = 1;
        end else begin
          rd_prev = mem[ea[12:2]];
        end
        ack_prev = 1;
        acks++;
        if (acks == chg_beat) begin
          i_addr = 32'h0000_2000;
          d_addr = 32'h0000_2000;
        end
      end
      if (advance) begin
        @(posedge clk);
        #1;
        widx = (widx + 1) % 16;
        d_wdata = wwords[widx];
      end
    end
    chk("burst_complete", 32'(acks), 32'(L));
    if (!done_seen) return;
    @(posedge clk);
    #1;
    if (!keep) begin
      if (exp_own == OWN_D) d_req = 1'b0;
      else i_req = 1'b0;
    end
  endtask

  typedef struct {
    logic        i_r;
    logic        d_r;
    logic        d_w;
    logic [31:0] i_a;
    logic [31:0] d_a;
    int          waitc;
    logic        exp_own;
    logic [31:0] exp_base;
  } vec_t;

  vec_t tab [5];

  initial begin
    logic own;
    logic [1:0] r;
    tab[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 0, OWN_I, 32'h0000_1220};
    tab[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0040, 2, OWN_D, 32'h0000_0040};
    tab[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0040, 1, OWN_D, 32'h0000_0040};
    tab[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_1FFC, 32'h0, 3, OWN_I, 32'h0000_1FE0};
    tab[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_105F, 0, OWN_D, 32'h0000_1040};
    for (int k = 0; k < 2048; k++) mem[k] = $urandom;
    for (int k = 0; k < 16; k++) wwords[k] = 32'h0000_00A0 + 32'(k);
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    @(negedge clk);
    chk("reset_gnt", {30'd0, gnt}, 32'd0);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_rvalid_done", {28'd0, i_rvalid, d_rvalid, i_done, d_done}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      #1;
      i_addr = tab[v].i_a; d_addr = tab[v].d_a; d_we = tab[v].d_w;
      i_req = tab[v].i_r; d_req = tab[v].d_r;
      run_burst(tab[v].exp_own, tab[v].exp_base, tab[v].exp_own & tab[v].d_w, tab[v].waitc, -1, -1, 0);
    end

    // Tie in one cycle: the winner completes, then the other gets the port after one idle cycle.
    @(posedge clk);
    #1;
    i_addr = 32'h0000_0300; d_addr = 32'h0000_0500; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    own = model_pick(1'b1, 1'b1);
    run_burst(own, own ? 32'h0000_0500 : 32'h0000_0300, 1'b0, 1, -1, -1, 0);
    run_burst(~own, own ? 32'h0000_0300 : 32'h0000_0500, 1'b0, 0, -1, -1, 0);

    // Both requesters held continuously for four bursts.
    @(posedge clk);
    #1;
    i_addr = 32'h0000_0600; d_addr = 32'h0000_0700; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int b = 0; b < 4; b++) begin
      own = model_pick(1'b1, 1'b1);
      run_burst(own, own ? 32'h0000_0700 : 32'h0000_0600, 1'b0, 0, -1, -1, 1);
    end
    i_req = 1'b0; d_req = 1'b0;

    // Address moved mid-burst: the latched line base must hold.
    @(posedge clk);
    #1;
    d_addr = 32'h0000_0180; d_we = 1'b0; d_req = 1'b1;
    run_burst(OWN_D, 32'h0000_0180, 1'b0, 1, 2, -1, 0);

    // Asynchronous reset during beat 3 of a D read.
    @(posedge clk);
    #1;
    d_addr = 32'h0000_0040; d_we = 1'b0; d_req = 1'b1;
    run_burst(OWN_D, 32'h0000_0040, 1'b0, 0, -1, 3, 0);

    // Randomized bursts against the arbitration and addressing rules.
    for (int n = 0; n < 24; n++) begin
      if (!i_req && !d_req) begin
        @(posedge clk);
        #1;
        r = 2'($urandom_range(1, 3));
        i_addr = $urandom & 32'h0000_1FFF;
        d_addr = $urandom & 32'h0000_1FFF;
        d_we = 1'($urandom_range(0, 1));
        for (int k = 0; k < 16; k++) wwords[k] = $urandom;
        i_req = r[0]; d_req = r[1];
      end
      own = model_pick(i_req, d_req);
      run_burst(own, (own ? d_addr : i_addr) & ~32'h1F, own & d_we, $urandom_range(0, 3), -1, -1, 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one main-memory port between the I-cache refill path and the D-cache refill/writeback path.
- Sits between the two cache controllers and the backing RAM in the MIPS wrapper.
- Moves whole cache lines as LINE_WORDS-beat 32-bit bursts.
- Serves one burst at a time. A granted burst always completes before the next grant.

Parameters:
- LINE_WORDS, 8: words per cache line (power of two, 2..16); 8 words = 256-bit line.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous reset, active-low
- i_req  in  1  I-cache line-read request; held high until i_done
- i_addr  in  ADDR_W  I-cache byte address; low log2(LINE_WORDS)+2 bits ignored
- i_rdata  out  32  read word to I-cache
- i_rvalid  out  1  i_rdata valid this cycle
- i_done  out  1  one-cycle pulse, last beat of I burst complete
- d_req  in  1  D-cache line request; held until d_done
- d_we  in  1  0 = line read (refill), 1 = line write (writeback); stable while d_req high
- d_addr  in  ADDR_W  D-cache byte address, line-aligned as above
- d_wdata  in  32  current write word
- d_wnext  out  1  pulse: d_wdata consumed, present next word next cycle
- d_rdata  out  32  read word to D-cache
- d_rvalid  out  1  d_rdata valid this cycle
- d_done  out  1  one-cycle pulse, D burst complete
- mem_en  out  1  memory beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_din  out  32  write data to memory
- mem_dout  in  32  read data from memory
- mem_ack  in  1  beat accepted (write) or mem_dout valid (read); may arrive same cycle as mem_en or later
- gnt  out  2  one-hot current owner: bit0 = I, bit1 = D; 00 when idle

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, beat = 0, gnt = 00.
  - mem_en, mem_we, all rvalid/done/wnext = 0.
  - rdata/mem_addr/mem_din = 0.
  - A burst in progress is abandoned immediately. The requester re-requests after reset.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If any req is high, latch the owner, line base = addr with low offset bits zeroed, and the we bit (I side is always read).
  - Set gnt, clear beat, go to BURST.
  - Decision is registered: first mem_en appears the cycle after req is sampled.
- Arbitration (default): fixed priority, D over I.
  - Simultaneous i_req and d_req: D is granted.
- BURST:
  - mem_en = 1, mem_addr = {base, beat, 2'b00}, mem_we = latched we, mem_din = d_wdata (combinational pass-through).
  - Beat completes on mem_ack.
  - Read beat: owner's rdata <= mem_dout and rvalid = 1 for one cycle (registered, 1 cycle after ack).
  - Write beat: d_wnext = 1 in the ack cycle (combinational with ack).
  - beat increments per ack. Ack on beat LINE_WORDS-1 goes to DONE.
  - mem_en deasserts in the cycle after the final ack.
- DONE:
  - Owner's done pulses for one cycle, aligned with the last rvalid for reads.
  - gnt -> 00, return to IDLE.
  - Requests are re-sampled in the following IDLE cycle: minimum 1 idle cycle between bursts.
- beat counter: log2(LINE_WORDS) bits. It never wraps inside a burst; it is cleared on entry to BURST.
- A req deasserted mid-burst is ignored; the burst still completes (protocol violation, not recovered).
- A req changing its addr mid-burst has no effect (base is latched).
- Back-to-back: a requester raising req again right after done competes normally. Under fixed priority a continuous d_req can starve I (accepted; see optional feature).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin. A 1-bit last-owner register (reset = D), so I wins the first tie. On a tie the requester not served last wins. No requester waits more than one burst.
- Undefined: fixed D-over-I priority as above. The last-owner register is absent.

Decomposition:
- Shared package/header (define.vh):
  - State encodings ARB_IDLE/ARB_BURST/ARB_DONE.
  - Owner codes OWN_I = 0, OWN_D = 1.
  - Default LINE_WORDS.
- Sub-module: mem_arb_pick, combinational grant select (fixed or round-robin under the macro), fed {i_req, d_req, last_owner}.
- The FSM and beat counter stay in mem_arbiter.

Test Plan:
- Reset mid-burst: assert rst_n = 0 at beat 3 of a D read -> mem_en, gnt, d_rvalid = 0 the same cycle. After release, the FSM is in IDLE with gnt = 00.
- I read, zero-wait memory (mem_ack = mem_en), i_addr = 0x0000_1234:
  - mem_addr sequence 0x1220, 0x1224, ... 0x123C.
  - 8 i_rvalid pulses with the memory words.
  - i_done coincides with the 8th i_rvalid.
- D writeback, mem_ack after 2 wait cycles per beat, d_addr = 0x0000_0040, words 0xA0..0xA7:
  - mem_we = 1 on every beat, mem_din matches each word.
  - 8 d_wnext pulses, one per ack.
  - d_done after the last ack.
- Simultaneous i_req and d_req in one cycle, macro off:
  - gnt = 10, D burst completes.
  - gnt = 00 for one cycle, then gnt = 01.
- Macro on, continuous d_req and i_req for 4 bursts -> grants alternate I, D, I, D (first I since last-owner resets to D).
- Address change mid-burst: d_addr changed to 0x2000 at beat 2 -> mem_addr continues on the original line base.
